// File: rtl/little_mem_pkg.sv
// Shared types and helpers for the mem_responder memory slave.
package little_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;

    // 33-bit arithmetic so a memory ending exactly at 2^32 does not wrap.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span);
        logic [32:0] offset;
        offset = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (offset < span);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-side native memory port: request fields from the core, response from the slave.
interface mem_responder_if;
    // mem_valid rises with a request and must stay high (fields stable) until
    // the single-cycle mem_ready pulse; rdata and fault are meaningful only then.
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        fault;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, fault
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, fault
    );
endinterface

// File: rtl/mem_responder_ram.sv
// Synchronous word RAM with four byte lanes, one write port and one read port.
module mem_responder_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     wstrb,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents survive reset on purpose: the preload happens while reset is held.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory slave with programmable wait states, byte-strobe writes and fault reporting.
module mem_responder
    import little_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                           clk,
    input  logic                           reset,
    mem_responder_if.slave                 bus,
    output logic                           fault_instr,
    output logic                           protocol_err,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data,
    output logic                           busy,
    output mem_state_t                     dbg_state
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;
    // The capture edge counts as the first decrement, so WAIT lasts WAIT_CYCLES cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    mem_state_t state, state_next;
    logic [3:0]       cnt, cnt_next;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic             instr_q;
    logic             fault_q;

    logic             capture;
    logic             perr_set;
    logic             fi_load;
    logic             fi_value;
    logic             req_fault;
    logic [IDX_W-1:0] req_idx;

    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [31:0]      ram_wdata;
    logic [3:0]       ram_wstrb;
    logic [IDX_W-1:0] ram_raddr;
    logic [31:0]      ram_rdata;

    assign req_fault = !addr_in_range(bus.mem_addr, BASE_ADDR, SPAN)
                       || ((bus.mem_addr[1:0] != 2'b00) && (bus.mem_wstrb != WSTRB_NONE));
    assign req_idx   = IDX_W'((bus.mem_addr - BASE_ADDR) >> 2);

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            wstrb_q      <= WSTRB_NONE;
            instr_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_instr  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                idx_q   <= req_idx;
                wdata_q <= bus.mem_wdata;
                wstrb_q <= bus.mem_wstrb;
                instr_q <= bus.mem_instr;
                fault_q <= req_fault;
            end
            if (fi_load) begin
                fault_instr <= fi_value;
            end
            if (perr_set) begin
                protocol_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        capture       = 1'b0;
        perr_set      = 1'b0;
        fi_load       = 1'b0;
        fi_value      = 1'b0;
        ram_we        = 1'b0;
        ram_waddr     = load_addr;
        ram_wdata     = load_data;
        ram_wstrb     = 4'hF;
        ram_raddr     = idx_q;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        bus.fault     = 1'b0;

        case (state)
            ST_IDLE: begin
                // Read from the live address so a zero-wait response has data next cycle.
                ram_raddr = req_idx;
                if (bus.mem_valid) begin
                    capture  = 1'b1;
                    cnt_next = WAIT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_RESP;
                        fi_load    = req_fault;
                        fi_value   = bus.mem_instr;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else if (load_en) begin
                    ram_we = 1'b1;
                end
            end

            ST_WAIT: begin
                if (!bus.mem_valid) begin
                    state_next = ST_IDLE;
                    perr_set   = 1'b1;
                end else if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                    fi_load    = fault_q;
                    fi_value   = instr_q;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end

            ST_RESP: begin
                bus.mem_ready = 1'b1;
                bus.fault     = fault_q;
                if (!fault_q && (wstrb_q == WSTRB_NONE)) begin
                    bus.mem_rdata = ram_rdata;
                end
                ram_we     = !fault_q && (wstrb_q != WSTRB_NONE);
                ram_waddr  = idx_q;
                ram_wdata  = wdata_q;
                ram_wstrb  = wstrb_q;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    mem_responder_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .wstrb(ram_wstrb),
        .raddr(ram_raddr),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) against a word-array model.
module tb_mem_responder;
    import little_mem_pkg::*;

    localparam int          DEPTH = 1024;
    localparam int          IDXW  = 10;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          W0    = 2;
    localparam int          W1    = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]            rst_d;
    logic [1:0]            valid_d, instr_d, load_en_d;
    logic [1:0][31:0]      addr_d, wdata_d, load_data_d;
    logic [1:0][3:0]       wstrb_d;
    logic [1:0][IDXW-1:0]  load_addr_d;
    logic [1:0]            ready_s, fault_s, fault_instr_s, perr_s, busy_s;
    logic [1:0][31:0]      rdata_s;
    mem_state_t            st0, st1;

    mem_responder_if bus0();
    mem_responder_if bus1();

    assign bus0.mem_valid = valid_d[0];
    assign bus0.mem_instr = instr_d[0];
    assign bus0.mem_addr  = addr_d[0];
    assign bus0.mem_wdata = wdata_d[0];
    assign bus0.mem_wstrb = wstrb_d[0];
    assign ready_s[0]     = bus0.mem_ready;
    assign rdata_s[0]     = bus0.mem_rdata;
    assign fault_s[0]     = bus0.fault;

    assign bus1.mem_valid = valid_d[1];
    assign bus1.mem_instr = instr_d[1];
    assign bus1.mem_addr  = addr_d[1];
    assign bus1.mem_wdata = wdata_d[1];
    assign bus1.mem_wstrb = wstrb_d[1];
    assign ready_s[1]     = bus1.mem_ready;
    assign rdata_s[1]     = bus1.mem_rdata;
    assign fault_s[1]     = bus1.fault;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .reset(rst_d[0]), .bus(bus0),
        .fault_instr(fault_instr_s[0]), .protocol_err(perr_s[0]),
        .load_en(load_en_d[0]), .load_addr(load_addr_d[0]), .load_data(load_data_d[0]),
        .busy(busy_s[0]), .dbg_state(st0)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .reset(rst_d[1]), .bus(bus1),
        .fault_instr(fault_instr_s[1]), .protocol_err(perr_s[1]),
        .load_en(load_en_d[1]), .load_addr(load_addr_d[1]), .load_data(load_data_d[1]),
        .busy(busy_s[1]), .dbg_state(st1)
    );

    // Reference model and scoreboard state.
    logic [31:0] model_mem [2][DEPTH];
    logic        model_fi  [2];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int s);
        return (s == 0) ? W0 : W1;
    endfunction

    function automatic bit model_fault(input logic [31:0] addr, input logic [3:0] wstrb);
        longint unsigned a, lo, hi;
        a  = longint'(addr);
        lo = longint'(BASE);
        hi = lo + 4 * DEPTH;
        return (a < lo) || (a >= hi) || ((addr % 4 != 0) && (wstrb != 4'h0));
    endfunction

    function automatic int model_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'(off / 4) % DEPTH;
    endfunction

    task automatic preload(input int s, input int idx, input logic [31:0] data);
        @(negedge clk);
        load_en_d[s]   = 1'b1;
        load_addr_d[s] = IDXW'(idx);
        load_data_d[s] = data;
        @(negedge clk);
        load_en_d[s] = 1'b0;
        model_mem[s][idx] = data;
    endtask

    // One complete request: latency, data, fault flags, then a clean return to idle.
    task automatic do_req(input int s, input bit instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input string tag);
        bit f;
        int idx;
        int cyc;
        f   = model_fault(addr, wstrb);
        idx = model_idx(addr);
        exp_q.push_back((f || wstrb != 4'h0) ? 32'h0 : model_mem[s][idx]);
        @(negedge clk);
        valid_d[s] = 1'b1;
        instr_d[s] = instr;
        addr_d[s]  = addr;
        wdata_d[s] = wdata;
        wstrb_d[s] = wstrb;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ready_s[s] && cyc < 40);
        check({tag, " latency"}, 32'(cyc), 32'(wait_of(s) + 1));
        check({tag, " rdata"}, rdata_s[s], exp_q.pop_front());
        check({tag, " fault"}, 32'(fault_s[s]), 32'(f));
        if (f) model_fi[s] = instr;
        if (!f && wstrb != 4'h0) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) model_mem[s][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        check({tag, " fault_instr"}, 32'(fault_instr_s[s]), 32'(model_fi[s]));
        valid_d[s] = 1'b0;
        @(negedge clk);
        check({tag, " ready_pulse"}, 32'(ready_s[s]), 32'd0);
        check({tag, " idle"}, 32'(busy_s[s]), 32'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  ws;
        int          cyc;
        int          r;
        bit          seen;

        rst_d = 2'b00;
        valid_d = '0; instr_d = '0; load_en_d = '0;
        addr_d = '0; wdata_d = '0; load_data_d = '0; wstrb_d = '0; load_addr_d = '0;
        model_fi[0] = 1'b0;
        model_fi[1] = 1'b0;

        // Preload while the core side is still held in reset.
        for (int i = 0; i < 16; i++) begin
            preload(0, i, (i == 5) ? 32'hDEADBEEF : $urandom);
            preload(1, i, $urandom);
        end
        for (int s = 0; s < 2; s++) begin
            check("rst ready", 32'(ready_s[s]), 32'd0);
            check("rst fault", 32'(fault_s[s]), 32'd0);
            check("rst fault_instr", 32'(fault_instr_s[s]), 32'd0);
            check("rst protocol_err", 32'(perr_s[s]), 32'd0);
            check("rst busy", 32'(busy_s[s]), 32'd0);
            check("rst rdata", rdata_s[s], 32'd0);
        end
        @(negedge clk);
        rst_d = 2'b11;

        // Directed cases on the two-wait-state instance.
        do_req(0, 1'b0, 32'h14, 32'h0, 4'h0, "rd_word5");
        do_req(0, 1'b0, 32'h14, 32'h11223344, 4'b0101, "wr_word5");
        do_req(0, 1'b0, 32'h14, 32'h0, 4'h0, "rd_merged");
        do_req(0, 1'b0, 32'h16, 32'hFFFFFFFF, 4'b0011, "wr_misaligned");
        do_req(0, 1'b0, 32'h14, 32'h0, 4'h0, "rd_after_fault");
        do_req(0, 1'b1, BASE + 4 * DEPTH, 32'h0, 4'h0, "fetch_oob");
        do_req(0, 1'b0, 32'h15, 32'h0, 4'h0, "rd_misaligned");
        do_req(0, 1'b0, BASE + 4 * DEPTH - 4, 32'hA5A55A5A, 4'hF, "wr_last");
        do_req(0, 1'b1, BASE + 4 * DEPTH - 4, 32'h0, 4'h0, "rd_last");

        // Preload attempts while a request is pending must be ignored.
        exp_q.push_back(model_mem[0][9]);
        @(negedge clk);
        valid_d[0] = 1'b1; instr_d[0] = 1'b0; addr_d[0] = 32'h24; wstrb_d[0] = 4'h0;
        load_en_d[0] = 1'b1; load_addr_d[0] = IDXW'(9); load_data_d[0] = 32'hCAFEF00D;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ready_s[0] && cyc < 40);
        check("busy_load rdata", rdata_s[0], exp_q.pop_front());
        valid_d[0] = 1'b0;
        load_en_d[0] = 1'b0;
        do_req(0, 1'b0, 32'h24, 32'h0, 4'h0, "busy_load readback");

        // Abandoned store: no response, no write, sticky error.
        @(negedge clk);
        valid_d[0] = 1'b1; addr_d[0] = 32'h1C; wdata_d[0] = $urandom; wstrb_d[0] = 4'hF;
        @(negedge clk);
        check("abort busy_in_wait", 32'(busy_s[0]), 32'd1);
        valid_d[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready_s[0]) seen = 1'b1;
        end
        check("abort no_ready", 32'(seen), 32'd0);
        check("abort protocol_err", 32'(perr_s[0]), 32'd1);
        check("abort busy", 32'(busy_s[0]), 32'd0);
        do_req(0, 1'b0, 32'h1C, 32'h0, 4'h0, "abort readback");

        // Randomized traffic over the preloaded window plus out-of-range addresses.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE + 4 * DEPTH + $urandom_range(0, 255);
            else if (r == 1) a = 32'hFFFF_FFFC;
            else             a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_req(i % 2, 1'($urandom_range(0, 1)), a, $urandom, ws, "rand");
        end
        check("protocol_err sticky", 32'(perr_s[0]), 32'd1);
        check("protocol_err other", 32'(perr_s[1]), 32'd0);

        // Reset in the middle of WAIT for a store.
        @(negedge clk);
        valid_d[0] = 1'b1; addr_d[0] = 32'h14; wdata_d[0] = 32'h0BADF00D; wstrb_d[0] = 4'hF;
        @(negedge clk);
        check("rst_wait busy_before", 32'(busy_s[0]), 32'd1);
        #1 rst_d[0] = 1'b0;
        #1;
        check("rst_wait ready", 32'(ready_s[0]), 32'd0);
        check("rst_wait busy", 32'(busy_s[0]), 32'd0);
        check("rst_wait protocol_err", 32'(perr_s[0]), 32'd0);
        check("rst_wait fault_instr", 32'(fault_instr_s[0]), 32'd0);
        model_fi[0] = 1'b0;
        valid_d[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_d[0] = 1'b1;
        do_req(0, 1'b0, 32'h14, 32'h0, 4'h0, "rst_wait readback");

        // Reset while the store response is on the bus: the write is dropped.
        @(negedge clk);
        valid_d[0] = 1'b1; addr_d[0] = 32'h18; wdata_d[0] = 32'h12345678; wstrb_d[0] = 4'hF;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ready_s[0] && cyc < 40);
        check("rst_resp ready_before", 32'(ready_s[0]), 32'd1);
        #1 rst_d[0] = 1'b0;
        #1;
        check("rst_resp ready", 32'(ready_s[0]), 32'd0);
        check("rst_resp busy", 32'(busy_s[0]), 32'd0);
        valid_d[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_d[0] = 1'b1;
        do_req(0, 1'b0, 32'h18, 32'h0, 4'h0, "rst_resp readback");

        // Zero-wait instance: back-to-back reads with mem_valid held high.
        @(negedge clk);
        valid_d[1] = 1'b1; instr_d[1] = 1'b0; addr_d[1] = 32'h0; wstrb_d[1] = 4'h0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ready_s[1] && cyc < 40);
        check("b2b first latency", 32'(cyc), 32'd1);
        check("b2b first rdata", rdata_s[1], model_mem[1][0]);
        addr_d[1] = 32'h4;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("b2b gap ready", 32'(ready_s[1]), 32'd0);
        end while (!ready_s[1] && cyc < 40);
        check("b2b spacing", 32'(cyc), 32'd2);
        check("b2b second rdata", rdata_s[1], model_mem[1][1]);
        valid_d[1] = 1'b0;
        @(negedge clk);
        check("b2b idle", 32'(busy_s[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
